scoreboard_hazard_unit: RTL

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_match.sv | 44 ++++
 rtl/scoreboard_hazard_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and width helpers for the scoreboard hazard unit.
package hazard_pkg;

    // Slot destinations are stored at a fixed maximum width; narrower RA_W zero-extends.
    localparam int unsigned RA_W_MAX = 16;

    typedef struct packed {
        logic                valid;
        logic                wb;
        logic [RA_W_MAX-1:0] dest;
        logic                is_load;
    } slot_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    function automatic int unsigned sel_w(input int unsigned depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source operand against every in-flight writer slot.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W  = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned SEL_W = sel_w(DEPTH)
) (
    input  logic [RA_W-1:0]   src_i,
    input  logic              src_use_i,
    input  slot_t [DEPTH-1:0] slots_i,
    output logic [DEPTH-1:0]  match_o,
    output logic [SEL_W-1:0]  youngest_o
);

    logic [RA_W_MAX-1:0] src_ext;
    logic                found;
    logic                unused_load;

    // Lowest matching slot wins: it holds the most recent producer.
    always_comb begin
        src_ext           = '0;
        src_ext[RA_W-1:0] = src_i;
        match_o           = '0;
        youngest_o        = '0;
        found             = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            match_o[k] = src_use_i & slots_i[k].valid & slots_i[k].wb &
                         (slots_i[k].dest == src_ext);
            if (match_o[k] && !found) begin
                youngest_o = SEL_W'(k + 1);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        unused_load = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            unused_load = unused_load ^ slots_i[k].is_load;
        end
    end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// In-order issue scoreboard: data-hazard stall/forward selection plus multicycle-op tracking.
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter  int unsigned RA_W   = 4,
    parameter  int unsigned NSRC   = 3,
    parameter  int unsigned DEPTH  = 2,
    parameter  int unsigned FWD_EN = 1,
    parameter  int unsigned MC_LAT = 8,
    localparam int unsigned SEL_W  = sel_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [NSRC*RA_W-1:0]  id_src,
    input  logic [NSRC-1:0]       id_src_use,
    input  logic                  id_wb_en,
    input  logic [RA_W-1:0]       id_dest,
    input  logic                  id_is_load,
    input  logic                  id_mc,
    input  logic                  flush,
    output logic                  stall,
    output logic [NSRC*SEL_W-1:0] fwd_sel,
    output logic                  mc_busy,
    output logic                  mc_done,
    output logic [15:0]           stall_count
);

    slot_t [DEPTH-1:0]          slot_q, slot_d;
    slot_t                      new_slot;
    logic [7:0]                 mc_cnt_q, mc_cnt_d;
    logic                       mc_done_q, mc_done_d;
    logic [15:0]                stall_cnt_q, stall_cnt_d;
    logic [NSRC-1:0][DEPTH-1:0] match;
    logic [NSRC-1:0][SEL_W-1:0] youngest;
    logic                       haz_any, haz_load_use, data_hazard, issue;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hazard_match #(
            .RA_W  (RA_W),
            .DEPTH (DEPTH),
            .SEL_W (SEL_W)
        ) u_match (
            .src_i      (id_src[i*RA_W +: RA_W]),
            .src_use_i  (id_src_use[i]),
            .slots_i    (slot_q),
            .match_o    (match[i]),
            .youngest_o (youngest[i])
        );
    end

    // With forwarding only a load still sitting in EX cannot be bypassed.
    always_comb begin
        haz_any      = 1'b0;
        haz_load_use = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            haz_any      = haz_any | (|match[i]);
            haz_load_use = haz_load_use | (match[i][0] & slot_q[0].is_load);
        end
        data_hazard = (FWD_EN != 0) ? haz_load_use : haz_any;
    end

    assign mc_busy     = (mc_cnt_q != '0);
    assign stall       = id_valid & (data_hazard | mc_busy);
    assign issue       = id_valid & ~stall & ~flush;
    assign fwd_sel     = (FWD_EN != 0) ? youngest : '0;
    assign mc_done     = mc_done_q;
    assign stall_count = stall_cnt_q;

    always_comb begin
        new_slot              = '0;
        new_slot.valid        = 1'b1;
        new_slot.wb           = id_wb_en;
        new_slot.dest[RA_W-1:0] = id_dest;
        new_slot.is_load      = id_is_load;

        slot_d = '0;
        if (!flush) begin
            slot_d[0] = issue ? new_slot : '0;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                slot_d[k] = slot_q[k-1];
            end
        end
    end

    // Flush wins over both a fresh load and a final decrement, so no completion pulse escapes.
    always_comb begin
        mc_cnt_d  = mc_cnt_q;
        mc_done_d = 1'b0;
        if (flush) begin
            mc_cnt_d = '0;
        end else if (issue && id_mc) begin
            mc_cnt_d = 8'(MC_LAT);
        end else if (mc_cnt_q != '0) begin
            mc_cnt_d  = mc_cnt_q - 8'd1;
            mc_done_d = (mc_cnt_q == 8'd1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            mc_cnt_q    <= '0;
            mc_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            mc_cnt_q    <= mc_cnt_d;
            mc_done_q   <= mc_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
